// File: rtl/mlp_collector_drain.sv
// Drains the mlp_1 collector FIFO into an AXI-Stream master through a credit-protected skid buffer.
// Define DRAIN_CHECKSUM_EN to append an XOR checksum beat (tlast) after every packet.
module mlp_collector_drain #(
  parameter int DATA_WIDTH = 64,
  parameter int PKT_WORDS  = 4,
  parameter int SKID_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] collector_ofifo_rdata,
  input  logic                  collector_ofifo_rdy,
  output logic                  collector_ofifo_ren,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [31:0]           word_count,
  output logic [15:0]           pkt_count
);
  localparam int AW = $clog2(SKID_DEPTH);
  localparam int OW = AW + 1;

  typedef enum logic {PAYLOAD = 1'b0, CSUM = 1'b1} state_e;

  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [OW-1:0]         occ_q, occ_d;
  logic                  inflight_q;
  logic [7:0]            beat_q;
  state_e                state_q;
  logic [31:0]           word_count_q, word_count_d;
  logic [15:0]           pkt_count_q;
`ifdef DRAIN_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] acc_q;
`endif

  logic has_data, is_last, beat, pay_beat, push;

  assign has_data = (occ_q != '0);
  assign is_last  = (beat_q == 8'(PKT_WORDS - 1));
  assign push     = inflight_q;

  // A read is only issued when a skid slot is guaranteed for it, counting the word still in flight.
  assign collector_ofifo_ren = ~reset & collector_ofifo_rdy &
                               ((occ_q + OW'(inflight_q)) < OW'(SKID_DEPTH));

`ifdef DRAIN_CHECKSUM_EN
  assign m_axis_tvalid = (state_q == CSUM) | has_data;
  assign m_axis_tdata  = (state_q == CSUM) ? acc_q : (has_data ? mem_q[rd_ptr_q] : '0);
  assign m_axis_tlast  = (state_q == CSUM);
`else
  assign m_axis_tvalid = has_data;
  assign m_axis_tdata  = has_data ? mem_q[rd_ptr_q] : '0;
  assign m_axis_tlast  = has_data & is_last;
`endif

  assign beat         = m_axis_tvalid & m_axis_tready;
  assign pay_beat     = beat & (state_q == PAYLOAD);
  assign occ_d        = occ_q + OW'(push) - OW'(pay_beat);
  assign word_count_d = word_count_q + 32'(pay_beat);
  assign word_count   = word_count_q;
  assign pkt_count    = pkt_count_q;

  // Storage is not reset; reads are masked by occupancy so stale entries never reach tdata.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= collector_ofifo_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= collector_ofifo_ren;
      occ_q      <= occ_d;
      if (push)     wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pay_beat) rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= PAYLOAD;
      beat_q       <= '0;
      word_count_q <= '0;
      pkt_count_q  <= '0;
`ifdef DRAIN_CHECKSUM_EN
      acc_q        <= '0;
`endif
    end else begin
      word_count_q <= word_count_d;
      case (state_q)
        PAYLOAD: begin
          if (pay_beat) begin
            beat_q <= is_last ? 8'd0 : beat_q + 8'd1;
`ifdef DRAIN_CHECKSUM_EN
            acc_q <= acc_q ^ m_axis_tdata;
            if (is_last) state_q <= CSUM;
`else
            if (is_last) pkt_count_q <= pkt_count_q + 16'd1;
`endif
          end
        end
        CSUM: begin
`ifdef DRAIN_CHECKSUM_EN
          if (beat) begin
            acc_q       <= '0;
            pkt_count_q <= pkt_count_q + 16'd1;
            state_q     <= PAYLOAD;
          end
`else
          state_q <= PAYLOAD;
`endif
        end
        default: state_q <= PAYLOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_collector_drain.sv
// Directed bench for mlp_collector_drain: collector model, beat monitor, hand-computed expectations.
module tb_mlp_collector_drain;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] rdata = '0;
  logic          rdy = 1'b0;
  logic          ren;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready = 1'b0;
  logic          tlast;
  logic [31:0]   word_count;
  logic [15:0]   pkt_count;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] next_val = 1;
  logic [DW-1:0] bq_data[$];
  logic          bq_last[$];

  always #5 clk = ~clk;

  mlp_collector_drain #(.DATA_WIDTH(DW), .PKT_WORDS(4), .SKID_DEPTH(4)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .collector_ofifo_rdata (rdata),
    .collector_ofifo_rdy   (rdy),
    .collector_ofifo_ren   (ren),
    .m_axis_tdata          (tdata),
    .m_axis_tvalid         (tvalid),
    .m_axis_tready         (tready),
    .m_axis_tlast          (tlast),
    .word_count            (word_count),
    .pkt_count             (pkt_count)
  );

  // Collector: each read returns the next value of a running sequence one cycle later.
  always @(posedge clk) begin
    if (ren) begin
`ifdef DRAIN_CHECKSUM_EN
      rdata <= 64'd1 << (next_val - 1);
`else
      rdata <= next_val;
`endif
      next_val <= next_val + 1;
    end
  end

  always @(posedge clk) begin
    if (!reset && tvalid && tready) begin
      bq_data.push_back(tdata);
      bq_last.push_back(tlast);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_beats(input int n, input int budget, output int used);
    used = 0;
    while (bq_data.size() < n && used < budget) begin
      @(negedge clk);
      used++;
    end
    chk("beat_timeout", 64'(bq_data.size() >= n), 64'd1);
  endtask

  initial begin
    int          k;
    int          rens;
    bit          gap;
    logic [63:0] exp_first;

    rdy = 1'b1;
    @(negedge clk);
    chk("rst_ren", ren, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_wc", word_count, 0);
    chk("rst_pc", pkt_count, 0);

`ifdef DRAIN_CHECKSUM_EN
    tready = 1'b1;
    reset  = 1'b0;
    while (next_val <= 4) @(negedge clk);
    rdy = 1'b0;
    wait_beats(5, 40, k);
    cyc(2);
    chk("cs_n", bq_data.size(), 5);
    chk("cs_d0", bq_data[0], 64'h1);
    chk("cs_d3", bq_data[3], 64'h8);
    chk("cs_sum", bq_data[4], 64'hF);
    chk("cs_l3", bq_last[3], 0);
    chk("cs_l4", bq_last[4], 1);
    chk("cs_wc", word_count, 4);
    chk("cs_pc", pkt_count, 1);
`else
    // Streaming: ren in the release cycle, tvalid two cycles later, then one beat per cycle.
    tready = 1'b1;
    reset  = 1'b0;
    #1 chk("st_ren", ren, 1);
    @(negedge clk);
    chk("st_lat1", tvalid, 0);
    @(negedge clk);
    chk("st_lat2", tvalid, 1);
    chk("st_first", tdata, 1);
    wait_beats(12, 50, k);
    chk("st_cycles", k, 12);
    chk("st_pc", pkt_count, 3);
    chk("st_wc", word_count, 12);
    rdy = 1'b0;
    cyc(6);

    // Backpressure from an empty buffer: exactly SKID_DEPTH reads, head held.
    tready = 1'b0;
    rdy    = 1'b1;
    rens   = 0;
    for (int i = 0; i < 20; i++) begin
      #1 if (ren) rens++;
      @(negedge clk);
    end
    chk("bp_rens", rens, 4);
    chk("bp_tvalid", tvalid, 1);
    chk("bp_hold", tdata, 64'(bq_data.size() + 1));
    tready = 1'b1;
    wait_beats(32, 100, k);
    rdy = 1'b0;
    cyc(6);

    // Starvation: one read every 4 cycles leaves mid-packet gaps.
    gap = 1'b0;
    for (int i = 0; i < 40; i++) begin
      rdy = (i % 4 == 0);
      #1 if (!tvalid && (bq_data.size() % 4) != 0) gap = 1'b1;
      @(negedge clk);
    end
    rdy = 1'b0;
    cyc(6);
    chk("sv_gap", gap, 1);

    for (int i = 0; i < bq_data.size(); i++) begin
      chk($sformatf("seq_d%0d", i), bq_data[i], 64'(i + 1));
      chk($sformatf("seq_l%0d", i), bq_last[i], 64'((i + 1) % 4 == 0));
    end
    chk("seq_wc", word_count, 64'(bq_data.size()));
    chk("seq_pc", pkt_count, 64'(bq_data.size() / 4));

    // Counter wrap: preload via the next-state net, then a single beat.
    tready = 1'b0;
    force dut.word_count_d = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 release dut.word_count_d;
    @(negedge clk);
    chk("wrap_pre", word_count, 32'hFFFF_FFFF);
    rdy = 1'b1;
    @(negedge clk);
    rdy    = 1'b0;
    tready = 1'b1;
    cyc(4);
    chk("wrap_post", word_count, 0);

    // Reset mid-operation: 3 words buffered plus one in flight, all discarded.
    bq_data.delete();
    bq_last.delete();
    tready = 1'b0;
    rdy    = 1'b1;
    cyc(3);
    rdy = 1'b0;
    cyc(1);
    rdy = 1'b1;
    cyc(1);
    #2 reset = 1'b1;
    #1;
    chk("mr_ren", ren, 0);
    chk("mr_tvalid", tvalid, 0);
    chk("mr_tlast", tlast, 0);
    chk("mr_tdata", tdata, 0);
    chk("mr_wc", word_count, 0);
    chk("mr_pc", pkt_count, 0);
    @(negedge clk);
    exp_first = next_val;
    reset  = 1'b0;
    tready = 1'b1;
    wait_beats(4, 40, k);
    rdy = 1'b0;
    chk("mr_d0", bq_data[0], exp_first);
    chk("mr_d1", bq_data[1], exp_first + 1);
    chk("mr_l0", bq_last[0], 0);
    chk("mr_l3", bq_last[3], 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
